// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display blocks.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
endpackage

// File: rtl/bcd_seg_lut.sv
// BCD nibble to active-low 7-segment pattern; purely combinational.
// Non-BCD codes render as a dash so corrupt counters are visible.
module bcd_seg_lut
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking, frame-synchronous
// digit shadowing and leading-zero suppression; outputs are registered (1 cycle).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    output logic [6:0]  seg,
    output logic [3:0]  AN,
    output logic        frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [15:0]   shadow;
    logic [3:0]    en_sh;

    logic          latch;
    logic [15:0]   digits_eff;
    logic [3:0]    en_eff;
    logic [3:0]    nibble;
    logic [6:0]    lut_seg;
    logic          in_blank;
    logic          lz_dark;
    logic          dark;

    // The output stage looks at the value being latched this cycle, so the new
    // frame's digits appear together with frame_start (matters when BLANK_CYCLES = 0).
    always_comb begin
        latch      = (cnt == '0) && (idx == '0);
        digits_eff = latch ? digits : shadow;
        en_eff     = latch ? digit_en : en_sh;
        nibble     = digits_eff[{idx, 2'b00} +: 4];
        in_blank   = (cnt < BLANK_END);
        lz_dark    = LZ_BLANK && (idx != '0) && ((digits_eff >> {idx, 2'b00}) == 16'h0000);
        dark       = !en_eff[idx] || lz_dark;
    end

    bcd_seg_lut u_lut (
        .bcd (nibble),
        .seg (lut_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            en_sh       <= '0;
            AN          <= AN_OFF;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (latch) begin
                shadow <= digits;
                en_sh  <= digit_en;
            end
            frame_start <= latch;

            if (in_blank || dark) begin
                AN  <= AN_OFF;
                seg <= SEG_OFF;
            end else begin
                AN  <= ~(4'b0001 << idx);
                seg <= lut_seg;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV = 8, BLANK_CYCLES = 2.
module tb_seg_scan_driver;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  digit_en = 4'hF;

    logic [6:0] seg_m, seg_n, seg_z;
    logic [3:0] an_m, an_n, an_z;
    logic       fs_m, fs_n, fs_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en),
        .seg(seg_m), .AN(an_m), .frame_start(fs_m));

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b0)) dut_nolz (
        .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en),
        .seg(seg_n), .AN(an_n), .frame_start(fs_n));

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(0), .LZ_BLANK(1'b1)) dut_b0 (
        .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en),
        .seg(seg_z), .AN(an_z), .frame_start(fs_z));

    function automatic logic [6:0] lut_ref(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {AN, seg} k cycles after reset release, for a frame showing d/en.
    function automatic logic [10:0] exp_out(input int k, input logic [15:0] d,
                                            input logic [3:0] en, input bit lz, input int bc);
        int c, s;
        logic [3:0]  nib;
        logic [15:0] up;
        c = (k - 1) % RD;
        s = ((k - 1) / RD) % 4;
        if (c < bc) return {4'b1111, 7'b1111111};
        nib = d[s*4 +: 4];
        up  = d >> (4 * s);
        if (!en[s] || (lz && s >= 1 && up == 16'h0000)) return {4'b1111, 7'b1111111};
        return {~(4'b0001 << s), lut_ref(nib)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        digits = 16'h1234; digit_en = 4'hF;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if (an_m !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an_m); end
        if (seg_m !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", seg_m); end
        if (fs_m !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", fs_m); end
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            ef = ((k % 32) == 1);
            ea = (((k - 1) % 8) < 2) ? 4'b1111 : an_tab[((k - 1) / 8) % 4];
            es = (((k - 1) % 8) < 2) ? 7'b1111111 : seg_tab[((k - 1) / 8) % 4];
            n_checks += 3;
            if (fs_m !== ef) begin n_fail++; $display("FAIL scan_fs k=%0d: got %b want %b", k, fs_m, ef); end
            if (an_m !== ea) begin n_fail++; $display("FAIL scan_an k=%0d: got %b want %b", k, an_m, ea); end
            if (seg_m !== es) begin n_fail++; $display("FAIL scan_seg k=%0d: got %b want %b", k, seg_m, es); end
        end
    endtask

    task automatic run_model(input string name, input int cycles,
                             input logic [15:0] d, input logic [3:0] en, input bit with_nolz);
        logic [10:0] e;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            e = exp_out(k, d, en, 1'b1, BC);
            n_checks += 2;
            if (an_m !== e[10:7]) begin n_fail++; $display("FAIL %s_an k=%0d: got %b want %b", name, k, an_m, e[10:7]); end
            if (seg_m !== e[6:0]) begin n_fail++; $display("FAIL %s_seg k=%0d: got %b want %b", name, k, seg_m, e[6:0]); end
            if (with_nolz) begin
                e = exp_out(k, d, en, 1'b0, BC);
                n_checks += 2;
                if (an_n !== e[10:7]) begin n_fail++; $display("FAIL %s_nolz_an k=%0d: got %b want %b", name, k, an_n, e[10:7]); end
                if (seg_n !== e[6:0]) begin n_fail++; $display("FAIL %s_nolz_seg k=%0d: got %b want %b", name, k, seg_n, e[6:0]); end
            end
        end
    endtask

    task automatic test_leading_zeros();
        digits = 16'h0050; digit_en = 4'hF;
        do_reset();
        run_model("lz", 32, 16'h0050, 4'hF, 1'b1);
    endtask

    task automatic test_tearing();
        logic [10:0] e;
        logic [15:0] d;
        digits = 16'h0001; digit_en = 4'hF;
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            d = (k <= 32) ? 16'h0001 : 16'h0009;
            e = exp_out(k, d, 4'hF, 1'b1, BC);
            n_checks += 3;
            if (an_m !== e[10:7]) begin n_fail++; $display("FAIL tear_an k=%0d: got %b want %b", k, an_m, e[10:7]); end
            if (seg_m !== e[6:0]) begin n_fail++; $display("FAIL tear_seg k=%0d: got %b want %b", k, seg_m, e[6:0]); end
            if (fs_m !== (k == 1 || k == 33)) begin n_fail++; $display("FAIL tear_fs k=%0d: got %b", k, fs_m); end
            if (k == 11) digits = 16'h0009;  // counter now at cnt=3 of slot 1
        end
    endtask

    task automatic test_invalid_enable();
        digits = 16'hA000; digit_en = 4'b0111;
        do_reset();
        run_model("inv_dis", 32, 16'hA000, 4'b0111, 1'b1);
        digit_en = 4'hF;
        do_reset();
        run_model("inv_en", 32, 16'hA000, 4'hF, 1'b1);
    endtask

    task automatic test_async_reset();
        bit found;
        digits = 16'h1234; digit_en = 4'hF;
        do_reset();
        found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (an_m === 4'b1011) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL async_find: AN never reached 1011 within 40 cycles"); end
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (an_m !== 4'b1111) begin n_fail++; $display("FAIL async_an: got %b want 1111", an_m); end
        if (seg_m !== 7'b1111111) begin n_fail++; $display("FAIL async_seg: got %b want 1111111", seg_m); end
        @(negedge clk);
        reset = 1'b0;
        run_model("restart", 16, 16'h1234, 4'hF, 1'b0);
    endtask

    task automatic test_blank0();
        logic [10:0] e;
        digits = 16'h1234; digit_en = 4'hF;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            e = exp_out(k, 16'h1234, 4'hF, 1'b1, 0);
            n_checks += 2;
            if (an_z !== e[10:7]) begin n_fail++; $display("FAIL b0_an k=%0d: got %b want %b", k, an_z, e[10:7]); end
            if (seg_z !== e[6:0]) begin n_fail++; $display("FAIL b0_seg k=%0d: got %b want %b", k, seg_z, e[6:0]); end
        end
    endtask

    task automatic test_invariants();
        logic [3:0] last_m, last_n;
        int run_m, run_n;
        last_m = 4'b1111; last_n = 4'b1111; run_m = BC; run_n = BC;
        digits = 16'h0000; digit_en = 4'hF;
        do_reset();
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            n_checks += 2;
            if ($countones(an_m) < 3) begin n_fail++; $display("FAIL inv_onehot k=%0d: AN=%b", k, an_m); end
            if ($countones(an_n) < 3) begin n_fail++; $display("FAIL inv_onehot_nolz k=%0d: AN=%b", k, an_n); end
            if (an_m === 4'b1111) run_m++;
            else begin
                if (last_m !== 4'b1111 && an_m !== last_m) begin
                    n_checks++;
                    if (run_m < BC) begin n_fail++; $display("FAIL inv_blank k=%0d: gap %0d want >= %0d", k, run_m, BC); end
                end
                last_m = an_m; run_m = 0;
            end
            if (an_n === 4'b1111) run_n++;
            else begin
                if (last_n !== 4'b1111 && an_n !== last_n) begin
                    n_checks++;
                    if (run_n < BC) begin n_fail++; $display("FAIL inv_blank_nolz k=%0d: gap %0d want >= %0d", k, run_n, BC); end
                end
                last_n = an_n; run_n = 0;
            end
            digits   = 16'($urandom);
            digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        end
    endtask

    initial begin
        test_reset();
        test_leading_zeros();
        test_tearing();
        test_invalid_enable();
        test_async_reset();
        test_blank0();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
